// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding, the 7-segment hex glyphs and the default idle line level.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic DEF_IDLE_LEVEL = 1'b1;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sequence_generator_seg7.sv
// Combinational hex digit to 7-segment decoder with a pass-through decimal point.
// Output is {dp,g,f,e,d,c,b,a}; zero latency.
module seg7_hex_decoder
    import seq_gen_pkg::*;
(
    input  logic [3:0] val,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, SEG_HEX[val]};

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: latches a pattern and shifts it out MSB-first at the tick rate,
// optionally repeating with an idle gap; frame count shown on a 7-segment digit.
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int   MAX_LEN    = 8,
    parameter int   LEN_W      = 4,
    parameter int   CNT_W      = 4,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic               repeat_en,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [3:0]         gap,
    output logic               serial_out,
    output logic               bit_valid,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [7:0]         seg
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [3:0]         gap_len_q, gap_len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               serial_out_q, serial_out_d;
    logic               bit_valid_q, bit_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [LEN_W-1:0]   len_clamped;
    logic [IDX_W-1:0]   last_idx;

    assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign last_idx    = IDX_W'(len_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        gap_len_d    = gap_len_q;
        idx_d        = idx_q;
        gap_cnt_d    = gap_cnt_q;
        serial_out_d = serial_out_q;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (stop) begin
            state_d      = S_IDLE;
            serial_out_d = IDLE_LEVEL;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        serial_out_d = IDLE_LEVEL;
                    end
                    if (start && (len != '0)) begin
                        state_d   = S_SEND;
                        pat_d     = pat;
                        len_d     = len_clamped;
                        gap_len_d = gap;
                        idx_d     = IDX_W'(len_clamped - 1'b1);
                    end
                end
                S_SEND: begin
                    if (tick) begin
                        serial_out_d = pat_q[idx_q];
                        bit_valid_d  = 1'b1;
                        if (idx_q == '0) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 1'b1;
                            if (repeat_en && (gap_len_q != 4'd0)) begin
                                state_d   = S_GAP;
                                gap_cnt_d = gap_len_q;
                            end else if (repeat_en) begin
                                idx_d = last_idx;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            idx_d = idx_q - 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    // Counter holds the ticks still to idle; the last one re-arms the frame.
                    if (tick) begin
                        serial_out_d = IDLE_LEVEL;
                        if (gap_cnt_q == 4'd1) begin
                            state_d = S_SEND;
                            idx_d   = last_idx;
                        end else begin
                            gap_cnt_d = gap_cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    serial_out_d = IDLE_LEVEL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            gap_len_q    <= '0;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            serial_out_q <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            gap_len_q    <= gap_len_d;
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            serial_out_q <= serial_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign serial_out = serial_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q != S_IDLE);

    seg7_hex_decoder u_seg (
        .val (4'(frame_cnt_q)),
        .dp  (busy),
        .seg (seg)
    );

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based transmit model.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, repeat_en = 1'b0;
    logic [7:0] pat = 8'h00;
    logic [3:0] len = 4'd0, gap = 4'd0;
    logic       serial_out, bit_valid, busy, frame_done;
    logic [3:0] frame_cnt;
    logic [7:0] seg;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sequence_generator dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .repeat_en(repeat_en), .pat(pat), .len(len), .gap(gap),
        .serial_out(serial_out), .bit_valid(bit_valid), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .seg(seg)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Independent glyph table {g..a}
    logic [6:0] glyph [0:15] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Model: a queue of pending tick actions; each pop is what the line shows on that tick.
    typedef struct {
        bit v;
        bit is_bit;
        bit last;
    } item_t;

    item_t      mq[$];
    bit         m_serial = 1'b1;
    bit         m_bv = 1'b0, m_fd = 1'b0;
    int         m_cnt = 0;
    bit [7:0]   m_pat;
    int         m_len, m_gap;

    function automatic void push_frame();
        for (int i = m_len - 1; i >= 0; i--) begin
            item_t it;
            it.v = m_pat[i]; it.is_bit = 1'b1; it.last = (i == 0);
            mq.push_back(it);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_serial = 1'b1; m_bv = 1'b0; m_fd = 1'b0; m_cnt = 0;
        end else begin
            m_bv = 1'b0; m_fd = 1'b0;
            if (stop) begin
                mq.delete();
                m_serial = 1'b1;
            end else if (mq.size() == 0) begin
                if (tick) m_serial = 1'b1;
                if (start && len != 0) begin
                    m_pat = pat;
                    m_len = (len > 8) ? 8 : int'(len);
                    m_gap = int'(gap);
                    push_frame();
                end
            end else if (tick) begin
                item_t it;
                it = mq.pop_front();
                m_serial = it.v;
                m_bv = it.is_bit;
                if (it.last) begin
                    m_fd = 1'b1;
                    m_cnt = (m_cnt + 1) % 16;
                    if (repeat_en) begin
                        for (int g = 0; g < m_gap; g++) begin
                            item_t idle_it;
                            idle_it.v = 1'b1; idle_it.is_bit = 1'b0; idle_it.last = 1'b0;
                            mq.push_back(idle_it);
                        end
                        push_frame();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit mb;
            mb = (mq.size() != 0);
            chk("serial_out", serial_out, m_serial);
            chk("bit_valid", bit_valid, m_bv);
            chk("frame_done", frame_done, m_fd);
            chk("frame_cnt", frame_cnt, m_cnt);
            chk("busy", busy, mb);
            chk("seg", seg, {mb, glyph[m_cnt]});
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] g, input logic rep);
        pat = p; len = l; gap = g; repeat_en = rep; start = 1'b1;
        nxt();
        start = 1'b0;
    endtask

    int exp2 [8] = '{0, 1, 1, 1, 1, 0, 1, 1};
    int nbv;
    logic [7:0] p5;

    initial begin
        repeat (3) nxt();
        chk("reset_serial", serial_out, 1);
        chk("reset_seg", seg, 8'h3F);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", frame_cnt, 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick = 1'b1;
        nxt();

        // Single 3-bit frame
        launch(8'h03, 4'd3, 4'd0, 1'b0);
        chk("t1_busy_after_start", busy, 1);
        nxt(); chk("t1_bit0", serial_out, 0); chk("t1_bv0", bit_valid, 1);
        nxt(); chk("t1_bit1", serial_out, 1);
        nxt(); chk("t1_bit2", serial_out, 1); chk("t1_fd", frame_done, 1);
        nxt(); chk("t1_cnt", frame_cnt, 1); chk("t1_seg", seg, 8'b0000_0110);

        // Repeat with gap of 2
        launch(8'b011, 4'd3, 4'd2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            nxt();
            chk("t2_serial", serial_out, exp2[i]);
            chk("t2_busy", busy, 1);
            chk("t2_fd", frame_done, (i == 2 || i == 7) ? 1 : 0);
        end
        stop = 1'b1; nxt(); stop = 1'b0; repeat_en = 1'b0;
        chk("t2_stop_busy", busy, 0);
        chk("t2_cnt", frame_cnt, 3);

        // Tick every 4th clock
        tick = 1'b0;
        launch(8'b101, 4'd3, 4'd0, 1'b0);
        nbv = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0 && bit_valid) nbv++;
            tick = (c % 4 == 0);
            nxt();
        end
        if (bit_valid) nbv++;
        chk("t3_bv_pulses", nbv, 3);
        chk("t3_cnt", frame_cnt, 4);
        tick = 1'b1;
        nxt();

        // Stop after second bit
        launch(8'h00, 4'd3, 4'd0, 1'b0);
        nxt();
        nxt();
        chk("t4_bit2_low", serial_out, 0);
        stop = 1'b1; nxt(); stop = 1'b0;
        chk("t4_serial_idle", serial_out, 1);
        chk("t4_busy", busy, 0);
        chk("t4_fd", frame_done, 0);
        chk("t4_cnt", frame_cnt, 4);
        pat = 8'hFF; len = 4'd4; start = 1'b1; stop = 1'b1;
        nxt(); start = 1'b0; stop = 1'b0;
        chk("t4_start_stop_busy", busy, 0);

        // len = 0 rejected, len = 12 clamps to 8
        launch(8'hFF, 4'd0, 4'd0, 1'b0);
        chk("t5_len0_busy", busy, 0);
        nxt(); chk("t5_len0_bv", bit_valid, 0);
        p5 = 8'hA5;
        launch(p5, 4'd12, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            nxt();
            chk("t5_clamp_bit", serial_out, p5[7 - i]);
            chk("t5_clamp_bv", bit_valid, 1);
            chk("t5_clamp_fd", frame_done, (i == 7) ? 1 : 0);
        end
        nxt(); chk("t5_clamp_idle", busy, 0); chk("t5_cnt", frame_cnt, 5);

        // Asynchronous reset mid-frame
        launch(8'h03, 4'd3, 4'd0, 1'b0);
        nxt();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_serial", serial_out, 1);
        chk("t6_rst_bv", bit_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", frame_cnt, 0);
        chk("t6_rst_seg", seg, 8'h3F);
        nxt(); rst = 1'b0; nxt();

        // Counter wrap
        for (int j = 0; j < 15; j++) begin
            launch(8'h01, 4'd1, 4'd0, 1'b0);
            nxt();
        end
        chk("t6_cnt15", frame_cnt, 15);
        chk("t6_seg_F", seg, 8'b0111_0001);
        launch(8'h01, 4'd1, 4'd0, 1'b0);
        nxt();
        chk("t6_wrap_cnt", frame_cnt, 0);
        chk("t6_wrap_seg", seg, 8'b0011_1111);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick      = ($urandom % 3) != 0;
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 40) == 0;
            repeat_en = $urandom % 2;
            pat       = 8'($urandom);
            len       = 4'($urandom % 16);
            gap       = 4'($urandom % 4);
            nxt();
        end
        stop = 1'b1; start = 1'b0; nxt();
        stop = 1'b0; nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
